// File: rtl/apb_nslave_master_if.sv
// apb_nslave_master_if: APB bus between one bridge and NUM_SLAVES slaves
interface apb_nslave_master_if #(
   parameter int AW         = 9,
   parameter int DW         = 8,
   parameter int NUM_SLAVES = 2
);
   logic [AW-1:0]            paddr;
   logic [NUM_SLAVES-1:0]    psel;
   logic                     penable;
   logic                     pwrite;
   logic [DW-1:0]            pwdata;
   logic [NUM_SLAVES*DW-1:0] prdata;
   logic [NUM_SLAVES-1:0]    pready;
   logic [NUM_SLAVES-1:0]    pslverr;
   modport master (output paddr, psel, penable, pwrite, pwdata, input prdata, pready, pslverr);
   modport slave (input paddr, psel, penable, pwrite, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/apb_nslave_master.sv
// apb_nslave_master: APB master bridge decoding NUM_SLAVES slaves with wait states, timeout and error reporting
module apb_nslave_master #(
   parameter int AW         = 9,
   parameter int DW         = 8,
   parameter int NUM_SLAVES = 2,
   parameter int TIMEOUT    = 16
) (
   input  logic                pclk,
   input  logic                preset,
   input  logic                transfer,
   input  logic                read_write,
   input  logic [AW-1:0]       apb_write_paddr,
   input  logic [DW-1:0]       apb_write_data,
   input  logic [AW-1:0]       apb_read_paddr,
   output logic [DW-1:0]       apb_read_data_out,
   output logic                busy,
   output logic                xfer_done,
   output logic                xfer_err,
   apb_nslave_master_if.master bus
);
   localparam int SEL_BITS = $clog2(NUM_SLAVES);
   localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
   state_t              state, state_d;
   logic [SEL_BITS-1:0] idx_q, new_idx;
   logic [CW-1:0]       wait_cnt;
   logic [AW-1:0]       new_addr;
   logic                dec_ok, ready, slverr, complete, abort, accept;
   assign new_addr = read_write ? apb_read_paddr : apb_write_paddr;
   assign new_idx  = new_addr[AW-1 -: SEL_BITS];
   assign dec_ok   = int'(new_idx) < NUM_SLAVES;
   assign ready    = bus.pready[idx_q];
   assign slverr   = bus.pslverr[idx_q];
   assign complete = state == ACCESS && ready;
   assign abort    = state == ACCESS && !ready && TIMEOUT > 0 && wait_cnt == CW'(TIMEOUT - 1);
   assign accept   = transfer && (state == IDLE || complete);
   assign busy     = state != IDLE;
   assign bus.penable = state == ACCESS;
   assign bus.psel = busy ? NUM_SLAVES'(1) << idx_q : '0;
   // next state: a decodable accept always starts SETUP, SETUP always advances, ACCESS ends on ready or timeout
   always_comb begin
      state_d = (accept && dec_ok) ? SETUP :
                (state == SETUP) ? ACCESS :
                (complete || abort) ? IDLE : state;
   end
   // state register
   always_ff @(posedge pclk) begin
      state <= preset ? IDLE : state_d;
   end
   // request capture, wait counter, completion pulses and read data
   always_ff @(posedge pclk) begin
      if (preset) begin
         idx_q             <= '0;
         bus.paddr         <= '0;
         bus.pwrite        <= 1'b0;
         bus.pwdata        <= '0;
         wait_cnt          <= '0;
         xfer_done         <= 1'b0;
         xfer_err          <= 1'b0;
         apb_read_data_out <= '0;
      end else begin
         if (accept && dec_ok) begin
            idx_q      <= new_idx;
            bus.paddr  <= new_addr;
            bus.pwrite <= !read_write;
            bus.pwdata <= read_write ? '0 : apb_write_data;
         end
         wait_cnt  <= (state == ACCESS && !ready && !abort) ? wait_cnt + CW'(1) : '0;
         xfer_done <= complete || abort || (accept && !dec_ok);
         xfer_err  <= (complete && slverr) || abort || (accept && !dec_ok);
         if (complete && !bus.pwrite && !slverr)
            apb_read_data_out <= bus.prdata[idx_q*DW +: DW];
      end
   end
endmodule

// File: tb/tb_apb_nslave_master.sv
// tb_apb_nslave_master: transaction-level randomized check of the APB bridge
module tb_apb_nslave_master;
   localparam int AW = 9;
   localparam int DW = 8;
   localparam int TO = 16;
   logic          pclk = 0, preset = 1, transfer = 0, transfer_b = 0, read_write = 0;
   logic [AW-1:0] waddr = 0, raddr = 0;
   logic [DW-1:0] wdata = 0, rdo, rdo_b;
   logic          busy, done, err, busy_b, done_b, err_b;
   int            checks = 0, failures = 0;
   bit            pend_done = 0, pend_err = 0;
   logic [DW-1:0] m_rdata = 0;
   apb_nslave_master_if #(.AW(AW), .DW(DW), .NUM_SLAVES(2)) ifa ();
   apb_nslave_master_if #(.AW(AW), .DW(DW), .NUM_SLAVES(3)) ifb ();
   apb_nslave_master #(.AW(AW), .DW(DW), .NUM_SLAVES(2), .TIMEOUT(TO)) dut (
      .pclk(pclk), .preset(preset), .transfer(transfer), .read_write(read_write),
      .apb_write_paddr(waddr), .apb_write_data(wdata), .apb_read_paddr(raddr),
      .apb_read_data_out(rdo), .busy(busy), .xfer_done(done), .xfer_err(err), .bus(ifa));
   apb_nslave_master #(.AW(AW), .DW(DW), .NUM_SLAVES(3), .TIMEOUT(TO)) dut_b (
      .pclk(pclk), .preset(preset), .transfer(transfer_b), .read_write(read_write),
      .apb_write_paddr(waddr), .apb_write_data(wdata), .apb_read_paddr(raddr),
      .apb_read_data_out(rdo_b), .busy(busy_b), .xfer_done(done_b), .xfer_err(err_b), .bus(ifb));
   assign ifb.pready  = '1;
   assign ifb.pslverr = '0;
   assign ifb.prdata  = '0;
   always #5 pclk = ~pclk;
   initial begin
      #2_000_000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask
   task automatic tick(input string tag);
      @(posedge pclk); #1;
      chk({tag, ".done"}, 32'(done), 32'(pend_done));
      chk({tag, ".err"}, 32'(err), 32'(pend_err));
      chk({tag, ".rdata"}, 32'(rdo), 32'(m_rdata));
      pend_done = 0;
      pend_err  = 0;
   endtask
   task automatic chk_idle(input string tag);
      chk({tag, ".busy"}, 32'(busy), 0);
      chk({tag, ".psel"}, 32'(ifa.psel), 0);
      chk({tag, ".penable"}, 32'(ifa.penable), 0);
   endtask
   task automatic chk_bus(input string tag, input bit pen, input int idx, input logic [AW-1:0] a, input bit rw, input logic [DW-1:0] wd);
      chk({tag, ".busy"}, 32'(busy), 1);
      chk({tag, ".psel"}, 32'(ifa.psel), 32'(1) << idx);
      chk({tag, ".penable"}, 32'(ifa.penable), 32'(pen));
      chk({tag, ".paddr"}, 32'(ifa.paddr), 32'(a));
      chk({tag, ".pwrite"}, 32'(ifa.pwrite), 32'(!rw));
      chk({tag, ".pwdata"}, 32'(ifa.pwdata), rw ? 0 : 32'(wd));
   endtask
   task automatic junk();
      transfer   = 1'($urandom);
      read_write = 1'($urandom);
      waddr      = AW'($urandom);
      raddr      = AW'($urandom);
      wdata      = DW'($urandom);
   endtask
   task automatic slave(input int idx, input bit rdy, input bit se, input logic [DW-1:0] rd);
      ifa.pready  = 2'($urandom);
      ifa.pslverr = 2'($urandom);
      ifa.prdata  = 16'($urandom);
      ifa.pready[idx] = rdy;
      if (rdy) begin
         ifa.pslverr[idx] = se;
         ifa.prdata[idx*DW +: DW] = rd;
      end
   endtask
   // one transfer issued in an accepting cycle; gap = idle cycles afterwards (0 chains the next request)
   task automatic xfer(input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] wd, input int waits,
                       input bit se, input logic [DW-1:0] rd, input int gap);
      int idx = int'(a[AW-1]);
      int c = 0;
      transfer   = 1;
      read_write = rw;
      wdata      = wd;
      waddr      = rw ? AW'($urandom) : a;
      raddr      = rw ? a : AW'($urandom);
      tick("setup");
      chk_bus("setup", 0, idx, a, rw, wd);
      junk();
      forever begin
         tick("access");
         chk_bus("access", 1, idx, a, rw, wd);
         if (c == waits) begin
            slave(idx, 1, se, rd);
            transfer  = 0;
            pend_done = 1;
            pend_err  = se;
            if (rw && !se) m_rdata = rd;
            break;
         end
         slave(idx, 0, 0, rd);
         junk();
         if (c == TO - 1) begin
            pend_done = 1;
            pend_err  = 1;
            tick("abort");
            chk_idle("abort");
            transfer = 0;
            break;
         end
         c++;
      end
      repeat (gap) begin
         tick("gap");
         chk_idle("gap");
      end
   endtask
   initial begin
      transfer = 1; transfer_b = 1; waddr = 9'h1A5; wdata = 8'h3C;
      repeat (2) begin
         @(posedge pclk); #1;
         chk("rst.busy", 32'(busy), 0);
         chk("rst.done", 32'(done), 0);
         chk("rst.err", 32'(err), 0);
         chk("rst.psel", 32'(ifa.psel), 0);
         chk("rst.penable", 32'(ifa.penable), 0);
         chk("rst.paddr", 32'(ifa.paddr), 0);
         chk("rst.pwrite", 32'(ifa.pwrite), 0);
         chk("rst.pwdata", 32'(ifa.pwdata), 0);
         chk("rst.rdata", 32'(rdo), 0);
         chk("rst.b_busy", 32'(busy_b), 0);
      end
      preset = 0; transfer = 0; transfer_b = 0;
      tick("release");
      chk_idle("release");
      xfer(0, 9'h1A5, 8'h3C, 0, 0, 8'h00, 1);
      xfer(1, 9'h012, 8'h55, 3, 0, 8'hA7, 1);
      chk("rd_wait.data", 32'(rdo), 32'h A7);
      xfer(0, 9'h133, 8'h5A, 1, 0, 8'h00, 0);
      xfer(1, 9'h044, 8'h00, 0, 0, 8'h6E, 1);
      xfer(1, 9'h0F0, 8'h00, 0, 1, 8'hFF, 1);
      chk("slverr.hold", 32'(rdo), 32'h6E);
      xfer(0, 9'h1FF, 8'h11, 100, 0, 8'h00, 1);
      read_write = 0; waddr = 9'h1A5; transfer_b = 1;
      @(posedge pclk); #1;
      transfer_b = 0;
      chk("dec.done", 32'(done_b), 1);
      chk("dec.err", 32'(err_b), 1);
      chk("dec.psel", 32'(ifb.psel), 0);
      chk("dec.busy", 32'(busy_b), 0);
      @(posedge pclk); #1;
      chk("dec.pulse", 32'(done_b), 0);
      waddr = 9'h100; transfer_b = 1;
      @(posedge pclk); #1;
      transfer_b = 0;
      chk("dec2.psel", 32'(ifb.psel), 32'b100);
      repeat (2) @(posedge pclk);
      #1;
      chk("dec2.done", 32'(done_b), 1);
      chk("dec2.err", 32'(err_b), 0);
      transfer = 1; read_write = 0; waddr = 9'h0AA; wdata = 8'h77;
      tick("mid.setup");
      transfer = 0;
      slave(0, 0, 0, 8'h00);
      @(posedge pclk); #1;
      chk("mid.penable", 32'(ifa.penable), 1);
      preset = 1;
      @(posedge pclk); #1;
      chk("mid.psel", 32'(ifa.psel), 0);
      chk("mid.penable0", 32'(ifa.penable), 0);
      chk("mid.busy", 32'(busy), 0);
      chk("mid.done", 32'(done), 0);
      preset = 0;
      m_rdata = 0;
      tick("mid.after");
      chk_idle("mid.after");
      for (int i = 0; i < 300; i++)
         xfer(1'($urandom), AW'($urandom), DW'($urandom),
              ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 20)) : int'($urandom_range(0, 4)),
              $urandom_range(0, 4) == 0, DW'($urandom), int'($urandom_range(0, 2)));
      tick("final");
      chk_idle("final");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
